// File: rtl/bypass_tagged_slice_array_pkg.sv
// Shared types and constants for the tagged bypass slice array.
// The routing tag pairs a vfid with a route_id and is attached to every
// beat of one packet on the user side of the bypass path.
package bypass_tagged_slice_array_pkg;

   localparam int BYPASS_TAG_DEPTH = 16;
   localparam int BYPASS_ID_BITS   = 6;
   localparam int BYPASS_DEST_BITS = 4;

   typedef struct packed {
      logic [BYPASS_ID_BITS-1:0]   vfid;
      logic [BYPASS_DEST_BITS-1:0] route_id;
   } bypass_tag_t;

   // Width of an occupancy counter that must be able to hold the value 'depth'
   function automatic int tag_cnt_bits(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/bypass_skid_stage.sv
// One register slice of the bypass data path: a 2-entry skid buffer with a
// registered ready toward the upstream side and a registered output beat.
// Unstalled latency is exactly one cycle; full throughput is sustained.
module bypass_skid_stage
   import bypass_tagged_slice_array_pkg::*;
#(
   parameter int DATA_BITS = 512
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_BITS-1:0]   in_data,
   input  logic [DATA_BITS/8-1:0] in_keep,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_BITS-1:0]   out_data,
   output logic [DATA_BITS/8-1:0] out_keep,
   output logic                   out_last
);

   localparam int BEAT_BITS = DATA_BITS + DATA_BITS/8 + 1;

   logic [BEAT_BITS-1:0] in_beat;
   logic [BEAT_BITS-1:0] out_beat_q;
   logic [BEAT_BITS-1:0] skid_beat_q;
   logic                 out_valid_q;
   logic                 skid_valid_q;
   logic                 ready_q;
   logic                 in_fire;
   logic                 out_free;
   logic                 skid_next;

   assign in_beat   = {in_data, in_keep, in_last};
   assign in_ready  = ready_q;
   assign out_valid = out_valid_q;
   assign {out_data, out_keep, out_last} = out_beat_q;

   // Decide whether the output register can take a new beat and whether the skid entry will be occupied next cycle
   always_comb begin
      in_fire   = in_valid && ready_q;
      out_free  = out_ready || !out_valid_q;
      skid_next = 1'b0;
      if (!out_free) begin
         skid_next = skid_valid_q || in_fire;
      end
   end

   // Move beats into the output register, parking one in the skid entry when the output is stalled
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         out_valid_q  <= 1'b0;
         out_beat_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_beat_q  <= '0;
         ready_q      <= 1'b0;
      end else begin
         if (out_free) begin
            if (skid_valid_q) begin
               out_valid_q <= 1'b1;
               out_beat_q  <= skid_beat_q;
            end else begin
               out_valid_q <= in_fire;
               if (in_fire) begin
                  out_beat_q <= in_beat;
               end
            end
         end else if (in_fire) begin
            skid_beat_q <= in_beat;
         end
         skid_valid_q <= skid_next;
         ready_q      <= !skid_next;
      end
   end

endmodule

// File: rtl/bypass_tagged_slice_array.sv
// N-stage register-slice pipeline for one bypass AXI4S stream, with each
// packet tagged (tid = vfid, tdest = route_id) from a tag FIFO that is fed
// by the bypass request metadata. The tag stays stable for the whole packet
// and is popped on the output tlast handshake.
// Optional statistics counters are built when BYPASS_SLICE_STATS_EN is defined.
module bypass_tagged_slice_array
   import bypass_tagged_slice_array_pkg::*;
#(
   parameter int N_STAGES  = 2,
   parameter int DATA_BITS = 512,
   parameter int ID_BITS   = 6,
   parameter int DEST_BITS = 4,
   parameter int TAG_DEPTH = BYPASS_TAG_DEPTH
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   input  logic [DATA_BITS-1:0]         s_axis_tdata,
   input  logic [DATA_BITS/8-1:0]       s_axis_tkeep,
   input  logic                         s_axis_tlast,
   input  logic                         s_tag_valid,
   output logic                         s_tag_ready,
   input  logic [ID_BITS-1:0]           s_tag_id,
   input  logic [DEST_BITS-1:0]         s_tag_dest,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic [DATA_BITS-1:0]         m_axis_tdata,
   output logic [DATA_BITS/8-1:0]       m_axis_tkeep,
   output logic                         m_axis_tlast,
   output logic [ID_BITS-1:0]           m_axis_tid,
   output logic [DEST_BITS-1:0]         m_axis_tdest,
   output logic [$clog2(TAG_DEPTH):0]   tag_cnt
`ifdef BYPASS_SLICE_STATS_EN
   ,
   output logic [31:0]                  pkt_cnt,
   output logic [31:0]                  stall_cnt
`endif
);

   localparam int KEEP_BITS = DATA_BITS/8;
   localparam int PTR_BITS  = $clog2(TAG_DEPTH);
   localparam int CNT_BITS  = tag_cnt_bits(TAG_DEPTH);

   typedef struct packed {
      logic [ID_BITS-1:0]   vfid;
      logic [DEST_BITS-1:0] route_id;
   } tag_t;

   // ------------------------------------------------------------------
   // Data path: chain of skid stages, index 0 is the network side and
   // index N_STAGES is the end of the pipe feeding the attach logic.
   // ------------------------------------------------------------------
   logic                 st_valid [N_STAGES+1];
   logic                 st_ready [N_STAGES+1];
   logic [DATA_BITS-1:0] st_data  [N_STAGES+1];
   logic [KEEP_BITS-1:0] st_keep  [N_STAGES+1];
   logic                 st_last  [N_STAGES+1];

   logic pipe_valid;
   logic pipe_ready;
   logic pipe_last;

   assign st_valid[0] = s_axis_tvalid;
   assign st_data[0]  = s_axis_tdata;
   assign st_keep[0]  = s_axis_tkeep;
   assign st_last[0]  = s_axis_tlast;
   assign s_axis_tready = st_ready[0];

   assign st_ready[N_STAGES] = pipe_ready;
   assign pipe_valid = st_valid[N_STAGES];
   assign pipe_last  = st_last[N_STAGES];

   for (genvar g = 0; g < N_STAGES; g++) begin : g_stage
      bypass_skid_stage #(
         .DATA_BITS (DATA_BITS)
      ) u_stage (
         .aclk      (aclk),
         .aresetn   (aresetn),
         .in_valid  (st_valid[g]),
         .in_ready  (st_ready[g]),
         .in_data   (st_data[g]),
         .in_keep   (st_keep[g]),
         .in_last   (st_last[g]),
         .out_valid (st_valid[g+1]),
         .out_ready (st_ready[g+1]),
         .out_data  (st_data[g+1]),
         .out_keep  (st_keep[g+1]),
         .out_last  (st_last[g+1])
      );
   end

   // ------------------------------------------------------------------
   // Tag FIFO: no fall-through, head is valid once the count is non-zero.
   // ------------------------------------------------------------------
   tag_t                tag_mem [TAG_DEPTH];
   logic [PTR_BITS-1:0] wr_ptr_q;
   logic [PTR_BITS-1:0] rd_ptr_q;
   logic [CNT_BITS-1:0] tag_cnt_q;
   logic [CNT_BITS-1:0] tag_cnt_next;
   logic                tag_ready_q;
   logic                tag_push;
   logic                tag_pop;
   logic                tag_avail;
   tag_t                tag_head;
   tag_t                tag_in;

   assign tag_in.vfid     = s_tag_id;
   assign tag_in.route_id = s_tag_dest;
   assign tag_push  = s_tag_valid && tag_ready_q;
   assign tag_avail = (tag_cnt_q != '0);
   assign tag_head  = tag_mem[rd_ptr_q];
   assign s_tag_ready = tag_ready_q;
   assign tag_cnt     = tag_cnt_q;

   // Next occupancy: a simultaneous push and pop leaves the count unchanged
   always_comb begin
      tag_cnt_next = tag_cnt_q;
      if (tag_push && !tag_pop) begin
         tag_cnt_next = tag_cnt_q + CNT_BITS'(1);
      end else if (!tag_push && tag_pop) begin
         tag_cnt_next = tag_cnt_q - CNT_BITS'(1);
      end
   end

   // Tag storage is written on push only; stale contents are hidden by tag_avail
   always_ff @(posedge aclk) begin
      if (tag_push) begin
         tag_mem[wr_ptr_q] <= tag_in;
      end
   end

   // FIFO pointers, occupancy and the registered not-full flag
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         tag_cnt_q   <= '0;
         tag_ready_q <= 1'b0;
      end else begin
         if (tag_push) begin
            wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
         end
         if (tag_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
         end
         tag_cnt_q   <= tag_cnt_next;
         tag_ready_q <= (tag_cnt_next != CNT_BITS'(TAG_DEPTH));
      end
   end

   // ------------------------------------------------------------------
   // Attach stage: the output only advances while a tag is visible, so
   // data arriving ahead of its tag simply backs up the pipe.
   // ------------------------------------------------------------------
   assign pipe_ready    = m_axis_tready && tag_avail;
   assign m_axis_tvalid = pipe_valid && tag_avail;
   assign m_axis_tdata  = st_data[N_STAGES];
   assign m_axis_tkeep  = st_keep[N_STAGES];
   assign m_axis_tlast  = pipe_last;
   assign m_axis_tid    = tag_avail ? tag_head.vfid : '0;
   assign m_axis_tdest  = tag_avail ? tag_head.route_id : '0;
   assign tag_pop       = m_axis_tvalid && m_axis_tready && pipe_last;

`ifdef BYPASS_SLICE_STATS_EN
   logic [31:0] pkt_cnt_q;
   logic [31:0] stall_cnt_q;

   assign pkt_cnt   = pkt_cnt_q;
   assign stall_cnt = stall_cnt_q;

   // Count completed packets and cycles where data waits for a missing tag
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pkt_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (tag_pop) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
         end
         if (pipe_valid && !tag_avail) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_bypass_tagged_slice_array.sv
// Directed self-checking bench for bypass_tagged_slice_array
// (N_STAGES=2, 32-bit data, TAG_DEPTH=4). Set BYPASS_SLICE_STATS_EN to
// also connect and check the statistics outputs.
module tb_bypass_tagged_slice_array;

   localparam int DW = 32;
   localparam int KW = DW/8;
   localparam int IW = 6;
   localparam int DB = 4;
   localparam int TD = 4;
   localparam int CW = $clog2(TD) + 1;

   logic          aclk;
   logic          aresetn;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [DW-1:0] s_axis_tdata;
   logic [KW-1:0] s_axis_tkeep;
   logic          s_axis_tlast;
   logic          s_tag_valid;
   logic          s_tag_ready;
   logic [IW-1:0] s_tag_id;
   logic [DB-1:0] s_tag_dest;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic          m_axis_tlast;
   logic [IW-1:0] m_axis_tid;
   logic [DB-1:0] m_axis_tdest;
   logic [CW-1:0] tag_cnt;
`ifdef BYPASS_SLICE_STATS_EN
   logic [31:0]   pkt_cnt;
   logic [31:0]   stall_cnt;
`endif

   int nChecks = 0;
   int nFail   = 0;

   bypass_tagged_slice_array #(
      .N_STAGES  (2),
      .DATA_BITS (DW),
      .ID_BITS   (IW),
      .DEST_BITS (DB),
      .TAG_DEPTH (TD)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .s_tag_valid   (s_tag_valid),
      .s_tag_ready   (s_tag_ready),
      .s_tag_id      (s_tag_id),
      .s_tag_dest    (s_tag_dest),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tid    (m_axis_tid),
      .m_axis_tdest  (m_axis_tdest),
      .tag_cnt       (tag_cnt)
`ifdef BYPASS_SLICE_STATS_EN
      ,
      .pkt_cnt       (pkt_cnt),
      .stall_cnt     (stall_cnt)
`endif
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic l);
      s_axis_tvalid = v;
      s_axis_tdata  = d;
      s_axis_tkeep  = '1;
      s_axis_tlast  = l;
   endtask

   task automatic pushTag(input logic [IW-1:0] id, input logic [DB-1:0] dest);
      s_tag_valid = 1'b1;
      s_tag_id    = id;
      s_tag_dest  = dest;
      tick();
      s_tag_valid = 1'b0;
   endtask

   // Stream nBeats of base+k, packets of pktLen beats, checking every output handshake
   task automatic runStream(input int nBeats, input int pktLen, input logic [DW-1:0] base,
                            input bit toggle, input logic [IW-1:0] tid0,
                            input logic [DB-1:0] dest0, input bit incr);
      int sent = 0;
      int got  = 0;
      for (int cyc = 0; cyc < 200 && got < nBeats; cyc++) begin
         bit inHs;
         bit outHs;
         int pk;
         m_axis_tready = toggle ? ((cyc % 2) == 0) : 1'b1;
         applyStimulus(sent < nBeats, base + DW'(sent), (sent % pktLen) == (pktLen - 1));
         inHs  = s_axis_tvalid && s_axis_tready;
         outHs = m_axis_tvalid && m_axis_tready;
         if (outHs) begin
            pk = incr ? (got / pktLen) : 0;
            checkOutput("stream_data", 64'(m_axis_tdata), 64'(base + DW'(got)));
            checkOutput("stream_last", 64'(m_axis_tlast), 64'((got % pktLen) == (pktLen - 1)));
            checkOutput("stream_tid",  64'(m_axis_tid),   64'(tid0 + IW'(pk)));
            checkOutput("stream_dest", 64'(m_axis_tdest), 64'(dest0 + DB'(pk)));
            checkOutput("stream_keep", 64'(m_axis_tkeep), 64'({KW{1'b1}}));
            got++;
         end
         tick();
         if (inHs) sent++;
      end
      applyStimulus(1'b0, '0, 1'b0);
      m_axis_tready = 1'b1;
      checkOutput("stream_count", 64'(got), 64'(nBeats));
   endtask

   initial begin
      aresetn       = 1'b0;
      s_tag_valid   = 1'b0;
      s_tag_id      = '0;
      s_tag_dest    = '0;
      m_axis_tready = 1'b0;
      applyStimulus(1'b0, '0, 1'b0);

      // Reset values
      tick();
      tick();
      checkOutput("rst_s_tready", 64'(s_axis_tready), 64'd0);
      checkOutput("rst_tag_ready", 64'(s_tag_ready), 64'd0);
      checkOutput("rst_tag_cnt", 64'(tag_cnt), 64'd0);
      checkOutput("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      checkOutput("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
      checkOutput("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
      checkOutput("rst_m_tid", 64'(m_axis_tid), 64'd0);
      checkOutput("rst_m_tdest", 64'(m_axis_tdest), 64'd0);
`ifdef BYPASS_SLICE_STATS_EN
      checkOutput("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
      checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
      aresetn = 1'b1;
      checkOutput("pre_edge_s_tready", 64'(s_axis_tready), 64'd0);
      tick();
      checkOutput("post_rst_s_tready", 64'(s_axis_tready), 64'd1);
      checkOutput("post_rst_tag_ready", 64'(s_tag_ready), 64'd1);

      // Basic tagging: 4-beat packet, two-cycle latency, tag held for the whole packet
      $display("[TB] basic tagging");
      m_axis_tready = 1'b1;
      pushTag(6'd3, 4'd5);
      checkOutput("t1_tag_cnt", 64'(tag_cnt), 64'd1);
      checkOutput("t1_idle_tvalid", 64'(m_axis_tvalid), 64'd0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, DW'(32'hA0 + i), i == 3);
         tick();
         if (i == 0) begin
            checkOutput("t1_latency", 64'(m_axis_tvalid), 64'd0);
         end else begin
            checkOutput("t1_tvalid", 64'(m_axis_tvalid), 64'd1);
            checkOutput("t1_tdata", 64'(m_axis_tdata), 64'(32'hA0 + i - 1));
            checkOutput("t1_tlast", 64'(m_axis_tlast), 64'd0);
            checkOutput("t1_tid", 64'(m_axis_tid), 64'd3);
            checkOutput("t1_tdest", 64'(m_axis_tdest), 64'd5);
         end
      end
      applyStimulus(1'b0, '0, 1'b0);
      tick();
      checkOutput("t1_last_tdata", 64'(m_axis_tdata), 64'h0A3);
      checkOutput("t1_last_tlast", 64'(m_axis_tlast), 64'd1);
      checkOutput("t1_last_tid", 64'(m_axis_tid), 64'd3);
      checkOutput("t1_last_tdest", 64'(m_axis_tdest), 64'd5);
      checkOutput("t1_cnt_before_pop", 64'(tag_cnt), 64'd1);
      tick();
      checkOutput("t1_cnt_after_pop", 64'(tag_cnt), 64'd0);
      checkOutput("t1_drained", 64'(m_axis_tvalid), 64'd0);

      // Data ahead of tag: output stays idle until the tag becomes visible
      $display("[TB] data before tag");
      applyStimulus(1'b1, DW'(32'hB0), 1'b0);
      tick();
      applyStimulus(1'b1, DW'(32'hB1), 1'b1);
      tick();
      applyStimulus(1'b0, '0, 1'b0);
      repeat (10) tick();
      checkOutput("t2_wait_tvalid", 64'(m_axis_tvalid), 64'd0);
      pushTag(6'd7, 4'd1);
      checkOutput("t2_b0_tvalid", 64'(m_axis_tvalid), 64'd1);
      checkOutput("t2_b0_tdata", 64'(m_axis_tdata), 64'h0B0);
      checkOutput("t2_b0_tlast", 64'(m_axis_tlast), 64'd0);
      checkOutput("t2_b0_tid", 64'(m_axis_tid), 64'd7);
      checkOutput("t2_b0_tdest", 64'(m_axis_tdest), 64'd1);
      tick();
      checkOutput("t2_b1_tvalid", 64'(m_axis_tvalid), 64'd1);
      checkOutput("t2_b1_tdata", 64'(m_axis_tdata), 64'h0B1);
      checkOutput("t2_b1_tlast", 64'(m_axis_tlast), 64'd1);
      checkOutput("t2_b1_tid", 64'(m_axis_tid), 64'd7);
      tick();
      checkOutput("t2_drained", 64'(m_axis_tvalid), 64'd0);
      checkOutput("t2_tag_cnt", 64'(tag_cnt), 64'd0);

      // Backpressure: 16-beat incrementing packet under alternating tready
      $display("[TB] backpressure");
      pushTag(6'd2, 4'd3);
      runStream(16, 16, '0, 1'b1, 6'd2, 4'd3, 1'b0);
      checkOutput("t3_tag_cnt", 64'(tag_cnt), 64'd0);
      tick();
      checkOutput("t3_drained", 64'(m_axis_tvalid), 64'd0);

      // Tag FIFO full: fifth push refused, then tags consumed in order
      $display("[TB] tag fifo full");
      for (int k = 0; k < 5; k++) begin
         pushTag(IW'(k), DB'(k + 8));
         if (k == 3) begin
            checkOutput("t4_ready_at_full", 64'(s_tag_ready), 64'd0);
            checkOutput("t4_cnt_at_full", 64'(tag_cnt), 64'd4);
         end
      end
      checkOutput("t4_cnt_after_extra", 64'(tag_cnt), 64'd4);
      checkOutput("t4_ready_after_extra", 64'(s_tag_ready), 64'd0);
      runStream(4, 1, DW'(32'hC0), 1'b0, 6'd0, 4'd8, 1'b1);
      checkOutput("t4_cnt_empty", 64'(tag_cnt), 64'd0);
      checkOutput("t4_ready_again", 64'(s_tag_ready), 64'd1);
      tick();
      checkOutput("t4_drained", 64'(m_axis_tvalid), 64'd0);

      // Reset mid-packet with queued tags, then a fresh tagged packet
      $display("[TB] reset mid-operation");
      pushTag(6'd4, 4'd0);
      pushTag(6'd5, 4'd0);
      pushTag(6'd6, 4'd0);
      checkOutput("t5_cnt_queued", 64'(tag_cnt), 64'd3);
      applyStimulus(1'b1, DW'(32'hE0), 1'b0);
      tick();
      applyStimulus(1'b1, DW'(32'hE1), 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("t5_inflight_tvalid", 64'(m_axis_tvalid), 64'd1);
      checkOutput("t5_inflight_tid", 64'(m_axis_tid), 64'd4);
      aresetn = 1'b0;
      #1;
      checkOutput("t5_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      checkOutput("t5_rst_tag_cnt", 64'(tag_cnt), 64'd0);
      checkOutput("t5_rst_tdata", 64'(m_axis_tdata), 64'd0);
      checkOutput("t5_rst_tid", 64'(m_axis_tid), 64'd0);
      checkOutput("t5_rst_s_tready", 64'(s_axis_tready), 64'd0);
      checkOutput("t5_rst_tag_ready", 64'(s_tag_ready), 64'd0);
`ifdef BYPASS_SLICE_STATS_EN
      checkOutput("t5_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif
      tick();
      tick();
      aresetn = 1'b1;
      tick();
      checkOutput("t5_recover_s_tready", 64'(s_axis_tready), 64'd1);
      pushTag(6'd9, 4'd2);
      runStream(1, 1, DW'(32'hD0), 1'b0, 6'd9, 4'd2, 1'b0);
      checkOutput("t5_tag_cnt", 64'(tag_cnt), 64'd0);
`ifdef BYPASS_SLICE_STATS_EN
      checkOutput("t5_pkt_cnt", 64'(pkt_cnt), 64'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/bypass_tagged_slice_array.md
Name: bypass_tagged_slice_array

Overview:
- Parametrised successor to the fixed-width bypass pipeline slices. It provides an N-stage, full-throughput register-slice pipeline for one bypass AXI4S data stream.
- It pairs each packet with a routing tag (vfid, route_id) taken from a tag FIFO fed by the bypass request metadata.
- The tag drives tid/tdest of the AXI4SR output, stable for the whole packet. This replaces combinational tagging from live metadata.
- It sits between the network bypass stack and the vIO switch, one instance per bypass data direction.

Parameters:
- N_STAGES, 2, number of skid-buffer stages on the data path (0 = combinational pass-through).
- DATA_BITS, 512, tdata width; tkeep is DATA_BITS/8.
- ID_BITS, 6, tid width (vfid).
- DEST_BITS, 4, tdest width (route_id).
- TAG_DEPTH, 16, tag FIFO depth; power of two, at least 2.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tvalid/tready/tdata/tkeep/tlast  in/out/in/in/in  1/1/DATA_BITS/DATA_BITS/8/1  network-side untagged stream.
- s_tag_valid  in  1  tag push request.
- s_tag_ready  out  1  tag FIFO not full.
- s_tag_id  in  ID_BITS  vfid of the next packet.
- s_tag_dest  in  DEST_BITS  route_id of the next packet.
- m_axis_tvalid/tready/tdata/tkeep/tlast  out/in/out/out/out  same widths as the s_axis side  tagged user-side stream.
- m_axis_tid  out  ID_BITS  packet vfid.
- m_axis_tdest  out  DEST_BITS  packet route_id.
- tag_cnt  out  $clog2(TAG_DEPTH)+1  tag FIFO occupancy.

Behaviour:
- Clock and reset: one clock, aclk. Reset is asynchronous and active-low on aresetn. All state clears immediately on assertion.
- Reset values: m_axis_tvalid=0, m_axis_tdata/tkeep/tlast/tid/tdest=0, s_axis_tready=0, s_tag_ready=0, tag_cnt=0.
- Ready after reset: s_axis_tready and s_tag_ready go to 1 on the first aclk edge after deassertion.
- Stage design: each stage is a 2-entry skid buffer with registered ready and registered output.
  - Accepts one beat per cycle while the downstream is ready.
  - Latency is exactly 1 cycle per stage when unstalled, so total is N_STAGES cycles.
  - s_axis_tready falls only when the stage's skid entry is occupied.
  - No beat is dropped, duplicated or reordered under any tready pattern.
- Tag FIFO: synchronous, TAG_DEPTH entries.
  - Push on s_tag_valid&&s_tag_ready. s_tag_ready = !full, registered from the count.
  - Push into an empty FIFO: the head becomes visible the cycle after the push; there is no fall-through.
  - Simultaneous push and pop: tag_cnt is unchanged; legal unless full, in which case s_tag_ready is already low and only the pop occurs.
- Attach stage (after the last slice):
  - tag_avail = tag_cnt!=0.
  - m_axis_tvalid = pipe_valid && tag_avail.
  - Pipe ready = m_axis_tready && tag_avail.
  - m_axis_tid/tdest = FIFO head, constant from the first to the last beat of a packet.
  - Pop occurs on m_axis_tvalid&&m_axis_tready&&m_axis_tlast.
- Data ahead of tag: the output stalls with tvalid=0 until a tag is visible. The pipeline backs up and s_axis_tready eventually falls. This is not an error.
- Tag ahead of data: tags queue; each packet consumes tags in FIFO order.
- Single-beat packets (tlast on the first beat) consume one tag each; back-to-back single-beat packets sustain one per cycle when tags are present.
- Reset mid-packet: in-flight beats and tags are discarded. The first beat after reset is treated as a packet start.
- AXI4S rule: m_axis_* fields hold stable while tvalid&&!tready.

Optional Feature:
- Macro BYPASS_SLICE_STATS_EN.
- Defined: adds outputs pkt_cnt[31:0], incremented on each output tlast handshake, and stall_cnt[31:0], incremented each cycle pipe_valid&&!tag_avail. Both reset to 0 and wrap at 2^32.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- lynxTypes gains bypass_tag_t {vfid[ID_BITS], route_id[DEST_BITS]} and constant BYPASS_TAG_DEPTH=16.
- One sub-module, bypass_skid_stage (parametrised DATA_BITS, carrying data/keep/last), instantiated N_STAGES times in a generate loop.
- The tag FIFO and attach logic stay in the top module.

Test Plan:
- Basic tagging: N_STAGES=2, push tag {id=3,dest=5}, then a 4-beat packet with tready=1 -> first output beat 2 cycles after the first input, tid=3/tdest=5 on all 4 beats, tag_cnt returns to 0 on tlast.
- Data before tag: 2-beat packet sent first, tag {id=7,dest=1} pushed 10 cycles later -> m_axis_tvalid=0 until the cycle after the push, then both beats out in order with tid=7, no loss.
- Backpressure: 16-beat incrementing-data packet, tready pattern 1,0,1,0... -> output data 0..15 in order, no duplicates, s_axis_tready low only while the skid is full.
- Tag FIFO full: TAG_DEPTH=4, push 5 tags {id=0..4}, no data -> s_tag_ready low after the 4th push, tag_cnt=4. Then 4 single-beat packets -> tid 0,1,2,3 in order.
- Reset mid-operation: aresetn low mid-packet with 3 tags queued -> outputs 0 immediately, tag_cnt=0. New tag {id=9,dest=2} plus 1-beat packet -> tid=9, tdest=2.
- Stats (BYPASS_SLICE_STATS_EN): 3 packets, with the first held 5 cycles for a tag -> pkt_cnt=3, stall_cnt=5.
